// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker for a two-tap LFSR stream (b[n] = b[n-TAP_A] ^ b[n-TAP_B]).
// Define PRBS_CHK_SAT_EN to make err_cnt/bit_cnt saturate at 16'hFFFF instead of wrapping.
module prbs_checker #(
  parameter int TAP_A    = 3,
  parameter int TAP_B    = 4,
  parameter int LOCK_CNT = 8,
  parameter int WIN      = 16,
  parameter int LOSS_ERR = 4
) (
  input  logic        clk,
  input  logic        ini,
  input  logic        bit_in,
  input  logic        bit_vld,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [15:0] bit_cnt
);

  localparam int SW = $clog2(TAP_B + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TAP_B:1] r_hist, w_hist_nxt;
  logic [SW-1:0] r_seed_cnt, w_seed_nxt;
  logic [7:0]    r_good_cnt, w_good_nxt;
  logic [15:0]   r_win_cnt, w_win_cnt_nxt;
  logic [15:0]   r_win_err, w_win_err_nxt;
  logic [15:0]   r_err_cnt, w_err_cnt_nxt;
  logic [15:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic          r_err_pulse, w_err_pulse_nxt;
  logic          w_pred, w_bad;

  function automatic logic [15:0] cnt_inc(input logic [15:0] c);
`ifdef PRBS_CHK_SAT_EN
    return (c == 16'hFFFF) ? c : c + 16'd1;
`else
    return c + 16'd1;
`endif
  endfunction

  // hist[1] is the most recent received bit; an all-zero history is the LFSR lockup state.
  assign w_pred = r_hist[TAP_A] ^ r_hist[TAP_B];
  assign w_bad  = (bit_in != w_pred) || (r_hist == '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_hist_nxt      = r_hist;
    w_seed_nxt      = r_seed_cnt;
    w_good_nxt      = r_good_cnt;
    w_win_cnt_nxt   = r_win_cnt;
    w_win_err_nxt   = r_win_err;
    w_err_cnt_nxt   = r_err_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_err_pulse_nxt = 1'b0;
    if (bit_vld) begin
      w_hist_nxt = {r_hist[TAP_B-1:1], bit_in};
      case (r_state)
        ST_HUNT: begin
          if (r_seed_cnt != SW'(TAP_B)) begin
            w_seed_nxt = r_seed_cnt + SW'(1);
          end else if (!w_bad) begin
            if (LOCK_CNT == 1) begin
              w_state_nxt   = ST_LOCKED;
              w_win_cnt_nxt = '0;
              w_win_err_nxt = '0;
            end else begin
              w_state_nxt = ST_CHECK;
              w_good_nxt  = 8'd1;
            end
          end
        end
        ST_CHECK: begin
          if (w_bad) begin
            w_state_nxt = ST_HUNT;
            w_good_nxt  = '0;
          end else if (r_good_cnt + 8'd1 == 8'(LOCK_CNT)) begin
            w_state_nxt   = ST_LOCKED;
            w_good_nxt    = '0;
            w_win_cnt_nxt = '0;
            w_win_err_nxt = '0;
          end else begin
            w_good_nxt = r_good_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          w_bit_cnt_nxt = cnt_inc(r_bit_cnt);
          w_win_cnt_nxt = r_win_cnt + 16'd1;
          if (w_bad) begin
            w_err_pulse_nxt = 1'b1;
            w_err_cnt_nxt   = cnt_inc(r_err_cnt);
            w_win_err_nxt   = r_win_err + 16'd1;
          end
          // Loss of lock takes priority over a window rollover on the same bit.
          if (w_bad && (r_win_err + 16'd1 == 16'(LOSS_ERR))) begin
            w_state_nxt   = ST_HUNT;
            w_seed_nxt    = '0;
            w_win_cnt_nxt = '0;
            w_win_err_nxt = '0;
          end else if (r_win_cnt + 16'd1 == 16'(WIN)) begin
            w_win_cnt_nxt = '0;
            w_win_err_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_seed_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge ini) begin
    if (ini) begin
      r_state     <= ST_HUNT;
      r_hist      <= '0;
      r_seed_cnt  <= '0;
      r_good_cnt  <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hist      <= w_hist_nxt;
      r_seed_cnt  <= w_seed_nxt;
      r_good_cnt  <= w_good_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_win_err   <= w_win_err_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_err_pulse <= w_err_pulse_nxt;
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single-bit errors, loss/reacquire, lockup, gapped valid, reset, counter wrap.
`timescale 1ns/1ps
module tb_prbs_checker;

  logic        clk;
  logic        ini;
  logic        bit_in;
  logic        bit_vld;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [15:0] bit_cnt;

  int checks   = 0;
  int failures = 0;
  int n_vld    = 0;
  int bad_vld_pulse = 0;
  logic [31:0] exp_q[$];

  // One period of b[n]=b[n-3]^b[n-4] starting 1111; bit i is stream bit i+1.
  logic [14:0] seq_tbl = 15'b010110010001111;

  prbs_checker dut (
    .clk       (clk),
    .ini       (ini),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ini = 1'b1; bit_vld = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ini = 1'b0;
    n_vld = 0;
    exp_q.delete();
  endtask

  // driver: one cycle per call; outputs sampled 1ns after the rising edge
  task automatic send(input logic b, input logic v);
    @(negedge clk);
    bit_in = b; bit_vld = v;
    @(posedge clk);
    #1;
    if (v) n_vld++;
    if (err_pulse) begin
      if (!v) bad_vld_pulse++;
      else if (exp_q.size() == 0) check("err_pulse_unexpected", n_vld, 0);
      else check("err_pulse_pos", n_vld, exp_q.pop_front());
    end
  endtask

  function automatic logic seq_bit(input int k);
    return seq_tbl[(k - 1) % 15];
  endfunction

  task automatic stream(input int upto, input int flip_a, input int flip_b,
                        input int ones_lo, input int ones_hi);
    int k;
    logic b;
    while (n_vld < upto) begin
      k = n_vld + 1;
      b = seq_bit(k);
      if (k == flip_a || k == flip_b) b = ~b;
      if (k >= ones_lo && k <= ones_hi) b = 1'b1;
      send(b, 1'b1);
    end
  endtask

  initial begin
    ini = 1'b1; bit_in = 1'b0; bit_vld = 1'b0;

    // A: clean stream, lock latency and bit counting
    do_reset();
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    stream(11, 0, 0, 0, -1);
    check("A_locked_bit11", locked, 0);
    stream(12, 0, 0, 0, -1);
    check("A_locked_bit12", locked, 1);
    check("A_bit_cnt_bit12", bit_cnt, 0);
    stream(100, 0, 0, 0, -1);
    check("A_err_cnt", err_cnt, 0);
    check("A_bit_cnt_100", bit_cnt, 88);

    // B: single flipped bits in consecutive windows stay locked
    do_reset();
    exp_q.push_back(35); exp_q.push_back(38); exp_q.push_back(39);
    stream(44, 35, 0, 0, -1);
    check("B_err_cnt_first", err_cnt, 3);
    check("B_locked_first", locked, 1);
    exp_q.push_back(45); exp_q.push_back(48); exp_q.push_back(49);
    stream(60, 45, 0, 0, -1);
    check("B_err_cnt_second", err_cnt, 6);
    check("B_locked_second", locked, 1);
    check("B_bit_cnt", bit_cnt, 48);
    check("B_pulses_left", exp_q.size(), 0);

    // async reset mid-lock, observed before the next rising edge
    #3 ini = 1'b1;
    #1;
    check("R_locked", locked, 0);
    check("R_err_cnt", err_cnt, 0);
    check("R_bit_cnt", bit_cnt, 0);
    @(negedge clk);
    ini = 1'b0;

    // C: forced ones give four bad bits in a row, loss then reacquire
    do_reset();
    exp_q.push_back(35); exp_q.push_back(36); exp_q.push_back(37); exp_q.push_back(38);
    stream(37, 0, 0, 35, 38);
    check("C_locked_bit37", locked, 1);
    stream(38, 0, 0, 35, 38);
    check("C_locked_bit38", locked, 0);
    check("C_err_cnt", err_cnt, 4);
    stream(49, 0, 0, 0, -1);
    check("C_locked_bit49", locked, 0);
    stream(50, 0, 0, 0, -1);
    check("C_locked_bit50", locked, 1);
    check("C_err_cnt_hold", err_cnt, 4);
    check("C_bit_cnt_hold", bit_cnt, 26);
    check("C_pulses_left", exp_q.size(), 0);

    // D: all-zero stream never locks
    do_reset();
    for (int i = 0; i < 100; i++) send(1'b0, 1'b1);
    check("D_locked", locked, 0);
    check("D_err_cnt", err_cnt, 0);

    // E: bit_vld toggling, random data on idle cycles
    do_reset();
    bad_vld_pulse = 0;
    for (int c = 1; c <= 23; c++) begin
      if (c % 2 == 1) send(seq_bit(n_vld + 1), 1'b1);
      else send(1'($urandom_range(0, 1)), 1'b0);
      if (c == 22) check("E_locked_cyc22", locked, 0);
    end
    check("E_locked_cyc23", locked, 1);
    exp_q.push_back(30); exp_q.push_back(33); exp_q.push_back(34);
    while (n_vld < 40) begin
      send(1'($urandom_range(0, 1)), 1'b0);
      send((n_vld + 1 == 30) ? ~seq_bit(n_vld + 1) : seq_bit(n_vld + 1), 1'b1);
    end
    check("E_err_cnt", err_cnt, 3);
    check("E_bit_cnt", bit_cnt, 28);
    check("E_pulse_invalid_cyc", bad_vld_pulse, 0);
    check("E_pulses_left", exp_q.size(), 0);

    // F: bit_cnt at its top value, then one more locked bit
    do_reset();
    stream(65547, 0, 0, 0, -1);
    check("F_bit_cnt_top", bit_cnt, 16'hFFFF);
    stream(65548, 0, 0, 0, -1);
`ifdef PRBS_CHK_SAT_EN
    check("F_bit_cnt_sat", bit_cnt, 16'hFFFF);
`else
    check("F_bit_cnt_wrap", bit_cnt, 16'h0000);
`endif
    check("F_locked", locked, 1);
    check("F_err_cnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker for the downstream end of the pseudo-random pattern generator path. It consumes one bit per valid cycle and self-synchronises to a two-tap LFSR sequence by predicting each bit from previously received bits. It declares lock after a run of correct predictions, then counts bit errors and drops lock when the error density is too high. It is used on the bench and on the board to qualify the generator's serial output.

## Interface
- TAP_A, 3, first feedback delay in bits; must satisfy 1 ≤ TAP_A < TAP_B
- TAP_B, 4, second feedback delay in bits; also the history depth
- LOCK_CNT, 8, consecutive good bits required to lock, 1..255
- WIN, 16, monitoring window length in valid bits while locked, 2..65535
- LOSS_ERR, 4, errors within one window that force loss of lock, 1..WIN
- clk  input  1  clock; all sampling on the rising edge
- ini  input  1  reset, asynchronous, active-high
- bit_in  input  1  received serial bit
- bit_vld  input  1  bit_in is valid this cycle
- locked  output  1  checker is in LOCKED
- err_pulse  output  1  one-cycle pulse for each bad bit while LOCKED
- err_cnt  output  16  bad bits counted while LOCKED
- bit_cnt  output  16  valid bits received while LOCKED

## Operation
- Reset (ini=1, asynchronous): state=HUNT; history, seed_cnt, good_cnt, win_cnt, win_err all 0; locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.
- bit_vld=0: all state holds; err_pulse=0.
- History hist[1..TAP_B] holds the last TAP_B received bits. It shifts on every valid bit in every state, always with the received bit, never the predicted one.
- Prediction: pred = hist[TAP_A] ^ hist[TAP_B]. A bit is bad if bit_in != pred, or if the whole history is zero (the all-zero lockup state is never valid).
- HUNT: seed_cnt counts valid bits up to TAP_B. Once seed_cnt = TAP_B, the next valid bit is evaluated: good → CHECK with good_cnt=1; bad → stay in HUNT, seed_cnt held at TAP_B.
- CHECK: good bit → good_cnt+1. When good_cnt reaches LOCK_CNT → LOCKED, with win_cnt=0 and win_err=0. Bad bit → HUNT with good_cnt=0. Errors are not counted in CHECK.
- LOCKED:
  - Every valid bit increments bit_cnt and win_cnt.
  - A bad bit pulses err_pulse and increments err_cnt and win_err.
  - When win_err reaches LOSS_ERR → HUNT, seed_cnt=0, locked=0.
  - When win_cnt reaches WIN → win_cnt=0, win_err=0.
  - If both occur on the same bit, loss of lock wins.
- err_cnt and bit_cnt hold their values across loss and reacquisition. Only ini clears them.
- A single corrupted channel bit causes exactly 3 bad bits (at offsets 0, TAP_A, TAP_B), because the checker is self-synchronising.

## Timing
- All outputs are registered and update on the rising edge that samples a valid bit. They are visible the cycle after bit_in is presented.
- Lock latency from reset with a clean stream: locked rises on the edge sampling valid bit number TAP_B+LOCK_CNT (12 with defaults).
- err_pulse is high for exactly one cycle per bad bit. It is never high on a cycle where bit_vld=0.
- Loss of lock takes effect on the edge sampling the LOSS_ERR-th bad bit of the window.
- ini asserted mid-stream clears everything immediately, without waiting for a clock. Reacquisition restarts from HUNT.

## Configuration
- PRBS_CHK_SAT_EN defined: err_cnt and bit_cnt saturate at 16'hFFFF.
- PRBS_CHK_SAT_EN undefined: both counters wrap from 16'hFFFF to 0.
- No other behaviour differs.

## Test plan
- Reset, then a repeating 15-bit m-sequence for b[n]=b[n-3]^b[n-4] seeded 1111, bit_vld=1 → locked rises on valid bit 12; err_cnt=0; bit_cnt=88 after 100 bits.
- Locked, flip one bit → err_pulse fires exactly 3 times (at the flipped bit, +3, +4); err_cnt=3; locked stays 1.
- Locked, stream forced to all ones → 4 bad bits in a row; locked falls on the 4th; err_cnt=4; reacquires after returning to the m-sequence.
- Stream of all zeros from reset → never locks; locked=0 and err_cnt=0 after 100 bits.
- bit_vld toggled 1/0 every cycle on a clean stream → lock on the 12th valid bit (cycle 23); err_pulse never asserted in an invalid cycle.
- ini pulsed mid-lock between clock edges → locked, err_cnt and bit_cnt read 0 before the next edge. Preload err_cnt near 16'hFFFF by forcing errors; with PRBS_CHK_SAT_EN defined it stays at FFFF, without it wraps to 0000.
